uart_rx: RTL and testbench

- Serial receiver that sits between the board RsRx pin and the io_controller. It turns the asynchronous 8N1 serial line into bytes.
- Bytes are delivered over a valid/ready handshake with a single-entry output buffer. The block also reports framing and overrun errors.
- Runs in the PLL-derived system clock domain, alongside the other io blocks.

---
 rtl/uart_rx.sv | 159 +++++++++++++++
 tb/tb_uart_rx.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx.sv
// 8N1 serial receiver with a single-entry valid/ready output buffer, plus framing/overrun reporting.
// Optional parity check is enabled by defining UART_RX_PARITY_EN (adds PARITY_ODD and parity_err).
module uart_rx #(
  parameter int DATA_W   = 8,
  parameter int BAUD_DIV = 54
`ifdef UART_RX_PARITY_EN
  , parameter bit PARITY_ODD = 1'b0
`endif
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              rx,
  output logic [DATA_W-1:0] rx_data,
  output logic              rx_valid,
  input  logic              rx_ready,
  output logic              frame_err,
  output logic              overrun,
  output logic              busy
`ifdef UART_RX_PARITY_EN
  , output logic            parity_err
`endif
);

  localparam int TW = (BAUD_DIV > 1) ? $clog2(BAUD_DIV) : 1;
  localparam int BW = (DATA_W > 1) ? $clog2(DATA_W) : 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
`ifdef UART_RX_PARITY_EN
    S_PARITY,
`endif
    S_STOP,
    S_WAIT
  } state_e;

  state_e            state_q, state_d;
  logic              rx_meta_q, rx_s_q;
  logic [TW-1:0]     tick_cnt_q, tick_cnt_d;
  logic [3:0]        samp_q, samp_d;
  logic [BW-1:0]     bit_idx_q, bit_idx_d;
  logic [DATA_W-1:0] shift_q, shift_d;
  logic [DATA_W-1:0] rx_data_q, rx_data_d;
  logic              rx_valid_q, rx_valid_d;
  logic              frame_err_q, frame_err_d;
  logic              overrun_q, overrun_d;
  logic              tick, mid_start, samp_last;
  logic              data_smp, stop_smp, busy_c;
  logic              par_ok, deliver, load;
`ifdef UART_RX_PARITY_EN
  logic              par_q, par_d, par_smp;
  logic              parity_err_q, parity_err_d;
`endif

  // Tick counter is parked at 0 in IDLE so sampling phase locks to the start edge.
  assign tick      = (state_q != S_IDLE) && (tick_cnt_q == TW'(BAUD_DIV - 1));
  assign mid_start = tick && (samp_q == 4'd7);
  assign samp_last = tick && (samp_q == 4'd15);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (!rx_s_q) state_d = S_START;
      S_START: if (mid_start) state_d = rx_s_q ? S_IDLE : S_DATA;
`ifdef UART_RX_PARITY_EN
      S_DATA:   if (samp_last && bit_idx_q == BW'(DATA_W - 1)) state_d = S_PARITY;
      S_PARITY: if (samp_last) state_d = S_STOP;
`else
      S_DATA:  if (samp_last && bit_idx_q == BW'(DATA_W - 1)) state_d = S_STOP;
`endif
      S_STOP:  if (samp_last) state_d = rx_s_q ? S_IDLE : S_WAIT;
      S_WAIT:  if (rx_s_q) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    busy_c   = (state_q != S_IDLE);
    data_smp = (state_q == S_DATA) && samp_last;
    stop_smp = (state_q == S_STOP) && samp_last;
`ifdef UART_RX_PARITY_EN
    par_smp  = (state_q == S_PARITY) && samp_last;
`endif
  end

  always_comb begin
    tick_cnt_d = (state_q == S_IDLE || tick) ? '0 : tick_cnt_q + 1'b1;
    samp_d     = (state_d != state_q) ? 4'd0 : (tick ? samp_q + 4'd1 : samp_q);
    bit_idx_d  = (state_q == S_START) ? '0 : (data_smp ? bit_idx_q + 1'b1 : bit_idx_q);
    shift_d    = shift_q;
    if (data_smp) shift_d[bit_idx_q] = rx_s_q;
`ifdef UART_RX_PARITY_EN
    par_d  = par_smp ? rx_s_q : par_q;
    par_ok = ((^shift_q) ^ par_q) == PARITY_ODD;
`else
    par_ok = 1'b1;
`endif
    deliver     = stop_smp && rx_s_q && par_ok;
    load        = deliver && (!rx_valid_q || rx_ready);
    frame_err_d = stop_smp && !rx_s_q;
    overrun_d   = deliver && rx_valid_q && !rx_ready;
`ifdef UART_RX_PARITY_EN
    parity_err_d = stop_smp && rx_s_q && !par_ok;
`endif
    // A drain and a new delivery in the same cycle keep the buffer full with the new byte.
    rx_valid_d = load || (rx_valid_q && !rx_ready);
    rx_data_d  = load ? shift_q : rx_data_q;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rx_meta_q   <= 1'b1;
      rx_s_q      <= 1'b1;
      tick_cnt_q  <= '0;
      samp_q      <= '0;
      bit_idx_q   <= '0;
      shift_q     <= '0;
      rx_data_q   <= '0;
      rx_valid_q  <= 1'b0;
      frame_err_q <= 1'b0;
      overrun_q   <= 1'b0;
`ifdef UART_RX_PARITY_EN
      par_q        <= 1'b0;
      parity_err_q <= 1'b0;
`endif
    end else begin
      rx_meta_q   <= rx;
      rx_s_q      <= rx_meta_q;
      tick_cnt_q  <= tick_cnt_d;
      samp_q      <= samp_d;
      bit_idx_q   <= bit_idx_d;
      shift_q     <= shift_d;
      rx_data_q   <= rx_data_d;
      rx_valid_q  <= rx_valid_d;
      frame_err_q <= frame_err_d;
      overrun_q   <= overrun_d;
`ifdef UART_RX_PARITY_EN
      par_q        <= par_d;
      parity_err_q <= parity_err_d;
`endif
    end
  end

  assign rx_data   = rx_data_q;
  assign rx_valid  = rx_valid_q;
  assign frame_err = frame_err_q;
  assign overrun   = overrun_q;
  assign busy      = busy_c;
`ifdef UART_RX_PARITY_EN
  assign parity_err = parity_err_q;
`endif

endmodule

// File: tb/tb_uart_rx.sv
// Randomised + directed bench for uart_rx: queue scoreboard fed by a frame-level model, popped by a monitor.
module tb_uart_rx;
  localparam int DW  = 8;
  localparam int BD  = 4;
  localparam int BIT = 16 * BD;
`ifdef UART_RX_PARITY_EN
  localparam int NPB = 1;
`else
  localparam int NPB = 0;
`endif

  logic clk = 1'b0, reset = 1'b1, rx = 1'b1, rx_ready = 1'b0;
  logic [DW-1:0] rx_data;
  logic rx_valid, frame_err, overrun, busy;
`ifdef UART_RX_PARITY_EN
  logic parity_err;
`endif

  uart_rx #(.DATA_W(DW), .BAUD_DIV(BD)
`ifdef UART_RX_PARITY_EN
    , .PARITY_ODD(1'b0)
`endif
  ) dut (
    .clk(clk), .reset(reset), .rx(rx), .rx_data(rx_data), .rx_valid(rx_valid),
    .rx_ready(rx_ready), .frame_err(frame_err), .overrun(overrun), .busy(busy)
`ifdef UART_RX_PARITY_EN
    , .parity_err(parity_err)
`endif
  );

  always #5 clk = ~clk;

  logic [DW-1:0] exp_q[$];
  int n_vec = 0, n_err = 0;
  int obs_fe = 0, obs_ov = 0, obs_pe = 0, exp_fe = 0, exp_ov = 0, exp_pe = 0;
  int cyc = 0, t_start = 0, t_rise = 0;
  bit busy_seen = 0, rnd_ready = 0, prev_hold = 0, prev_valid = 0;
  logic [DW-1:0] prev_data = '0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] want);
    n_vec++;
    if (act !== want) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", nm, act, want, cyc);
    end
  endtask

  // Frame-level model: the queue stands for the one-entry buffer plus anything still in flight.
  task automatic expect_frame(input logic [DW-1:0] d, input bit stop, input bit par_good);
    if (!stop)          exp_fe++;
    else if (!par_good) exp_pe++;
    else if (exp_q.size() != 0) exp_ov++;
    else exp_q.push_back(d);
  endtask

  task automatic step();
    @(posedge clk); #1;
    if (rnd_ready) rx_ready = 1'($urandom % 2);
  endtask

  task automatic bit_out(input logic v, input int n);
    rx = v;
    for (int i = 0; i < n; i++) step();
  endtask

  // pbit < 0 sends the correct parity bit; 0/1 forces that value.
  task automatic send(input logic [DW-1:0] d, input bit stop, input int pbit);
    bit pb, good;
    pb = (pbit < 0) ? ^d : pbit[0];
    good = (NPB == 0) || ((^d ^ pb) == 1'b0);
    expect_frame(d, stop, good);
    t_start = cyc;
    bit_out(1'b0, BIT);
    for (int i = 0; i < DW; i++) bit_out(d[i], BIT);
    if (NPB != 0) bit_out(pb, BIT);
    bit_out(stop, BIT);
  endtask

  task automatic wait_drain(input string nm);
    for (int i = 0; i < 300 && exp_q.size() != 0; i++) step();
    if (exp_q.size() != 0) chk(nm, 32'(exp_q.size()), 0);
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_rx_valid"}, rx_valid, 0);
    chk({tag, "_rx_data"}, rx_data, 0);
    chk({tag, "_frame_err"}, frame_err, 0);
    chk({tag, "_overrun"}, overrun, 0);
    chk({tag, "_busy"}, busy, 0);
  endtask

  task automatic monitor();
    forever begin
      @(negedge clk);
      cyc++;
      if (!reset) begin
        if (frame_err) obs_fe++;
        if (overrun) obs_ov++;
`ifdef UART_RX_PARITY_EN
        if (parity_err) obs_pe++;
`endif
        if (frame_err || overrun) chk("fe_ov_exclusive", 32'(frame_err && overrun), 0);
        if (busy) busy_seen = 1;
        if (rx_valid && !prev_valid) t_rise = cyc;
        if (prev_hold) chk("data_stable", rx_data, prev_data);
        if (rx_valid && rx_ready) begin
          if (exp_q.size() == 0) chk("unexpected_byte", rx_data, 32'hFFFF_FFFF);
          else chk("rx_data", rx_data, exp_q.pop_front());
        end
        prev_hold  = rx_valid && !rx_ready;
        prev_valid = rx_valid;
        prev_data  = rx_data;
      end else begin
        prev_hold = 0;
        prev_valid = 0;
      end
    end
  endtask

  task automatic main_seq();
    int lat;
    logic [DW-1:0] d;
    bit st;
    repeat (3) @(posedge clk);
    #1;
    chk_reset_outputs("rst");
    reset = 0;
    bit_out(1'b1, 10);

    // Basic frame with consumer always ready, plus latency window
    rx_ready = 1;
    send(8'h55, 1'b1, -1);
    wait_drain("drain_55");
    lat = t_rise - t_start;
    chk("latency_win", 32'(lat >= 608 + NPB*BIT && lat <= 616 + NPB*BIT), 1);
    bit_out(1'b1, BIT);
    chk("busy_after_55", busy, 0);
    chk("fe_count_55", obs_fe, exp_fe);

    // Buffer full: second byte overruns, first stays put
    rx_ready = 0;
    send(8'hA3, 1'b1, -1);
    bit_out(1'b1, BIT);
    send(8'h3C, 1'b1, -1);
    bit_out(1'b1, BIT);
    chk("ovr_valid_held", rx_valid, 1);
    chk("ovr_data_held", rx_data, 8'hA3);
    chk("ovr_count", obs_ov, exp_ov);
    rx_ready = 1;
    step();
    rx_ready = 0;
    bit_out(1'b1, 3);
    chk("ovr_valid_drained", rx_valid, 0);
    chk("ovr_queue_empty", 32'(exp_q.size()), 0);

    // False start: short glitch must not produce a byte or an error
    rx_ready = 1;
    busy_seen = 0;
    bit_out(1'b0, 16);
    bit_out(1'b1, 3 * BIT);
    chk("glitch_busy_seen", busy_seen, 1);
    chk("glitch_busy_idle", busy, 0);
    chk("glitch_valid", rx_valid, 0);
    chk("glitch_fe", obs_fe, exp_fe);

    // Bad stop bit followed by a held break
    send(8'h00, 1'b0, -1);
    bit_out(1'b0, 3 * BIT);
    chk("break_busy", busy, 1);
    chk("break_fe_count", obs_fe, exp_fe);
    bit_out(1'b1, 6);
    chk("break_idle", busy, 0);
    chk("break_valid", rx_valid, 0);

    // Reset in the middle of a frame
    bit_out(1'b0, BIT);
    bit_out(1'b1, 2 * BIT);
    reset = 1;
    bit_out(1'b1, 3);
    chk_reset_outputs("midrst");
    reset = 0;
    bit_out(1'b1, 12 * BIT);
    send(8'hC7, 1'b1, -1);
    wait_drain("drain_c7");
    bit_out(1'b1, BIT);
    chk("c7_fe", obs_fe, exp_fe);

`ifdef UART_RX_PARITY_EN
    send(8'h07, 1'b1, 0);
    bit_out(1'b1, BIT);
    chk("par_bad_count", obs_pe, exp_pe);
    chk("par_bad_valid", rx_valid, 0);
    send(8'h07, 1'b1, 1);
    wait_drain("drain_par_good");
    bit_out(1'b1, BIT);
`endif

    // Random frames, random consumer stalls, occasional bad stop
    rnd_ready = 1;
    for (int k = 0; k < 20; k++) begin
      d  = DW'($urandom);
      st = ($urandom % 6) != 0;
      send(d, st, -1);
      wait_drain("drain_rand");
      bit_out(1'b1, 8 + int'($urandom % 80));
    end
    rnd_ready = 0;
    rx_ready = 1;
    bit_out(1'b1, 4);

    chk("final_fe", obs_fe, exp_fe);
    chk("final_ov", obs_ov, exp_ov);
    chk("final_pe", obs_pe, exp_pe);
    chk("final_queue", 32'(exp_q.size()), 0);
    chk("final_valid", rx_valid, 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  endtask

  initial begin
    fork
      monitor();
      main_seq();
    join_any
  end

endmodule
